// File: rtl/mips_multiciclo_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/mem/writeback,
// mem_ready stalls, retired-instruction counter.
// Ports: clk, rst_n, opcode, zero, mem_ready in; datapath controls,
// estado, halted, instr_cnt out.
module mips_multiciclo_ctrl #(
  parameter int CNT_W       = 32,
  parameter bit HALT_ILEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [1:0]       ULAOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       estado,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             pc_write;
  logic             pc_write_cond;
  logic             is_bne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign is_bne = (opcode == OP_BNE);

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ULASrcA       = 1'b0;
    ULASrcB       = 2'b00;
    ULAOp         = 2'b00;
    PCSource      = 2'b00;
    halted        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead  = 1'b1;
        ULASrcB  = 2'b01;
        // PC and IR only move once the fetch really completes
        pc_write = mem_ready;
        IRWrite  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ULASrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            if (HALT_ILEGAL) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ULASrcA = 1'b1;
        ULAOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ULASrcA       = 1'b1;
        ULAOp         = is_bne ? 2'b11 : 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    pc_en = pc_write | (pc_write_cond & (zero ^ is_bne));
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign estado    = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_multiciclo_ctrl.sv
// Random instruction stream against two controller configurations,
// checked per cycle by an instruction-level reference model.
module tb_mips_multiciclo_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ULASrcA;
    logic [1:0] ULASrcB;
    logic [1:0] ULAOp;
    logic [1:0] PCSource;
    logic [3:0] estado;
    logic       halted;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  ov_t         oa, ob;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_multiciclo_ctrl #(.CNT_W(32), .HALT_ILEGAL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(oa.pc_en), .IorD(oa.IorD),
    .MemRead(oa.MemRead), .MemWrite(oa.MemWrite),
    .IRWrite(oa.IRWrite), .MemtoReg(oa.MemtoReg),
    .RegDst(oa.RegDst), .RegWrite(oa.RegWrite),
    .ULASrcA(oa.ULASrcA), .ULASrcB(oa.ULASrcB),
    .ULAOp(oa.ULAOp), .PCSource(oa.PCSource),
    .estado(oa.estado), .halted(oa.halted), .instr_cnt(cnt_a)
  );

  mips_multiciclo_ctrl #(.CNT_W(4), .HALT_ILEGAL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(ob.pc_en), .IorD(ob.IorD),
    .MemRead(ob.MemRead), .MemWrite(ob.MemWrite),
    .IRWrite(ob.IRWrite), .MemtoReg(ob.MemtoReg),
    .RegDst(ob.RegDst), .RegWrite(ob.RegWrite),
    .ULASrcA(ob.ULASrcA), .ULASrcB(ob.ULASrcB),
    .ULAOp(ob.ULAOp), .PCSource(ob.PCSource),
    .estado(ob.estado), .halted(ob.halted), .instr_cnt(cnt_b)
  );

  // model: per DUT, current step and remaining steps of the instruction
  int          cur[2];
  int          pth[2][4];
  int          plen[2];
  int          pidx[2];
  longint      cnt[2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic ov_t expect_out(int s, logic mr, logic z,
                                     logic [5:0] op);
    ov_t o;
    o = '0;
    o.estado = 4'(s);
    case (s)
      1: begin
        o.MemRead = 1'b1; o.ULASrcB = 2'b01;
        o.pc_en = mr; o.IRWrite = mr;
      end
      2: o.ULASrcB = 2'b11;
      3: begin o.ULASrcA = 1'b1; o.ULASrcB = 2'b10; end
      4: begin o.MemRead = 1'b1; o.IorD = 1'b1; end
      5: begin o.RegWrite = 1'b1; o.MemtoReg = 1'b1; end
      6: begin o.MemWrite = 1'b1; o.IorD = 1'b1; end
      7: begin o.ULASrcA = 1'b1; o.ULAOp = 2'b10; end
      8: begin o.RegWrite = 1'b1; o.RegDst = 1'b1; end
      9: begin
        o.ULASrcA = 1'b1; o.PCSource = 2'b01;
        if (op == 6'b000101) begin
          o.ULAOp = 2'b11; o.pc_en = !z;
        end else begin
          o.ULAOp = 2'b01; o.pc_en = z;
        end
      end
      10: begin o.pc_en = 1'b1; o.PCSource = 2'b10; end
      11: begin o.ULASrcA = 1'b1; o.ULASrcB = 2'b10; end
      12: o.RegWrite = 1'b1;
      13: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(int m, int s);
    pth[m][plen[m]] = s;
    plen[m]++;
  endtask

  // steps an instruction visits after decode
  task automatic load_path(int m, logic [5:0] op, bit il_halt);
    plen[m] = 0;
    pidx[m] = 0;
    case (op)
      6'b100011: begin push(m, 3); push(m, 4); push(m, 5); end
      6'b101011: begin push(m, 3); push(m, 6); end
      6'b000000: begin push(m, 7); push(m, 8); end
      6'b000100, 6'b000101: push(m, 9);
      6'b000010: push(m, 10);
      6'b001000: begin push(m, 11); push(m, 12); end
      default: if (il_halt) push(m, 13);
    endcase
  endtask

  task automatic advance(int m);
    if (pidx[m] == plen[m]) begin
      cnt[m]++;
      cur[m] = 1;
    end else begin
      cur[m] = pth[m][pidx[m]];
      pidx[m]++;
    end
  endtask

  task automatic step(int m, bit il_halt);
    case (cur[m])
      0: cur[m] = 1;
      1: if (mem_ready) cur[m] = 2;
      2: begin load_path(m, opcode, il_halt); advance(m); end
      13: ;
      default:
        if (!((cur[m] == 4 || cur[m] == 6) && !mem_ready))
          advance(m);
    endcase
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cur[m] = 0; plen[m] = 0; pidx[m] = 0; cnt[m] = 0;
    end
  endtask

  task automatic check_all();
    ov_t ea, eb;
    ea = expect_out(cur[0], mem_ready, zero, opcode);
    eb = expect_out(cur[1], mem_ready, zero, opcode);
    chk("dutA", {12'd0, cnt_a, oa}, {12'd0, 32'(cnt[0]), ea});
    chk("dutB", {40'd0, cnt_b, ob}, {40'd0, 4'(cnt[1]), eb});
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [7];
    logic [5:0] r;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
              6'b000101, 6'b000010, 6'b001000};
    if ($urandom_range(0, 19) == 0) begin
      do begin
        r = 6'($urandom);
      end while (r inside {6'b100011, 6'b101011, 6'b000000,
                           6'b000100, 6'b000101, 6'b000010,
                           6'b001000});
      return r;
    end
    return legal[$urandom_range(0, 6)];
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cur[1] <= 1) opcode = pick_op();
      zero      = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      #1 check_all();
      if ($urandom_range(0, 199) == 0) begin
        // asynchronous reset in the middle of the low phase
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(posedge clk);
        step(0, 1'b1);
        step(1, 1'b0);
        @(negedge clk);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
